spi_txn_arbiter: RTL and testbench
==================================

// Module: spi_txn_arbiter
// PURPOSE
//  Sequences multi-byte SPI transactions through the 8-bit SPI master's register port (addr 0..6, two-cycle access).
//  Arbitrates between two requesters, e.g. LMS7002 config and FPGA-internal register access.
//  Uses the SSO control bit to hold SS_n low across all bytes of one transaction.
//  Returns the received bytes to the requester.
// PARAMETERS
//  NBYTES      4     bytes per transaction; MSB byte sent first; range 1..4
//  NSLAVES     2     width of the slave-select one-hot mask
//  TIMEOUT_CYC 4096  per-byte RRDY watchdog limit, in clk cycles (SPI_ARB_TIMEOUT_EN only)
// PORTS
//  clk           in   1          system clock
//  reset_n       in   1          async active-low reset
//  reqN_valid    in   1          N=0,1; request, held high until reqN_done
//  reqN_slave    in   NSLAVES    N=0,1; one-hot slave mask for the request
//  reqN_wdata    in   8*NBYTES   N=0,1; transmit data
//  reqN_done     out  1          N=0,1; 1-cycle pulse, transaction finished
//  rdata         out  8*NBYTES   received bytes; valid while reqN_done is high, held afterwards
//  err           out  1          1-cycle pulse with reqN_done when the transaction timed out
//  spi_select    out  1          SPI core chip select
//  read_n        out  1          SPI core read strobe, active low
//  write_n       out  1          SPI core write strobe, active low
//  mem_addr      out  3          SPI core register address
//  data_from_cpu out  16         SPI core write data
//  data_to_cpu   in   16         SPI core read data (registered inside the core)
//  readyfordata  in   1          SPI core TRDY
//  dataavailable in   1          SPI core RRDY
// BEHAVIOUR
//  Reset values: all outputs 0, except read_n=1 and write_n=1. Arbiter last-grant=1, so req0 wins first.
//  Bus access: spi_select plus read_n or write_n asserted for exactly 2 clks, then 1 idle clk before the next access.
//  - mem_addr and data_from_cpu are stable over both access cycles.
//  - Read data is captured from data_to_cpu on the edge that ends the 2nd access cycle.
//  Arbitration (IDLE only): round-robin.
//  - Both requesters valid: grant the one not granted last.
//  - Grant is held until DONE; slave mask and wdata are latched at grant.
//  FSM, one bus access per state where applicable:
//  - IDLE -> CLR_STAT: write addr2 = 0; clears stale RRDY/ROE/TOE/EOP.
//  - -> WR_SS: write addr5 = {0, slave mask}.
//  - -> SSO_ON: write addr3 = 0x0400.
//  - -> WAIT_T: wait for readyfordata=1.
//  - -> WR_TX: write addr1 = {8'h0, current byte}.
//  - -> WAIT_R: wait for dataavailable=1.
//  - -> RD_RX: read addr0; shift data_to_cpu[7:0] into rdata LSB.
//  - Byte count < NBYTES: -> WAIT_T. Byte count = NBYTES: -> SSO_OFF.
//  - SSO_OFF: write addr3 = 0x0000; SS_n deasserts.
//  - -> DONE: pulse reqN_done for the granted requester -> IDLE.
//  A requester that is granted and then drops valid is ignored; the transaction still completes and done still pulses.
//  A new request arriving mid-transaction waits; no preemption.
//  reset_n low mid-transaction: immediate return to IDLE, strobes released. The SPI core shares the reset, so SSO clears too.
//  Byte counter width is clog2(NBYTES+1). rdata is cleared at grant.
//  Bytes leave MSB first: wdata[8*NBYTES-1 -: 8] goes out first.
// CONFIGURATION
//  SPI_ARB_TIMEOUT_EN defined:
//  - A counter runs in WAIT_T and WAIT_R and reloads on each state entry.
//  - On reaching TIMEOUT_CYC: jump to SSO_OFF, then DONE with err=1. rdata holds the bytes received so far.
//  SPI_ARB_TIMEOUT_EN undefined: no counter; err is tied 0; the wait states can wait forever.
// TESTING
//  1. req0 valid, slave=2'b01, wdata=0xA5C30F81, core model loops MOSI to MISO
//     -> access order addr 2,5,3,(1,0)x4,3; rdata=0xA5C30F81; one req0_done pulse.
//  2. req0 and req1 valid in the same cycle -> req0 served first, then req1 without re-arbitration gap > 1 IDLE clk.
//     Next dual request -> req1 served first.
//  3. Hold readyfordata=0 for 50 clks in WAIT_T -> no addr1 write until TRDY rises; no extra accesses issued.
//  4. Assert reset_n=0 during byte 2 -> strobes 1, done 0, FSM IDLE.
//     A fresh request afterwards completes normally with all 4 bytes.
//  5. SPI_ARB_TIMEOUT_EN, TIMEOUT_CYC=64, dataavailable stuck 0 -> addr3=0 write issued.
//     req0_done and err pulse together at cycle 64 + SSO_OFF access.
//  6. Protocol check on every access: strobe width exactly 2 clks; addr/data stable; >= 1 idle clk between accesses.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that sequences multi-byte SPI transactions through the SPI master's register port.
// Optional per-byte RRDY/TRDY watchdog enabled with `define SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter #(
  parameter int unsigned NBYTES      = 4,
  parameter int unsigned NSLAVES     = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [NSLAVES-1:0]    req0_slave,
  input  logic [8*NBYTES-1:0]   req0_wdata,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic [NSLAVES-1:0]    req1_slave,
  input  logic [8*NBYTES-1:0]   req1_wdata,
  output logic                  req1_done,
  output logic [8*NBYTES-1:0]   rdata,
  output logic                  err,
  output logic                  spi_select,
  output logic                  read_n,
  output logic                  write_n,
  output logic [2:0]            mem_addr,
  output logic [15:0]           data_from_cpu,
  input  logic [15:0]           data_to_cpu,
  input  logic                  readyfordata,
  input  logic                  dataavailable
);

  localparam int unsigned DW = 8 * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR_STAT, S_WR_SS, S_SSO_ON, S_WAIT_T,
    S_WR_TX, S_WAIT_R, S_RD_RX, S_SSO_OFF, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          ph_q, ph_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic [NSLAVES-1:0]  slave_q, slave_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          done_q, done_d;
  logic                sel_q, sel_d;
  logic                rdn_q, rdn_d;
  logic                wrn_q, wrn_d;
  logic [2:0]          addr_q, addr_d;
  logic [15:0]         dout_q, dout_d;

  logic                acc_en, acc_rd, acc_last, pick;
  logic [2:0]          acc_addr;
  logic [15:0]         acc_data;
  logic                unused_ok;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                errp_q, errp_d;
  logic                err_q, err_d;
`endif

  assign unused_ok = ^{data_to_cpu[15:8], 32'(TIMEOUT_CYC)};

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    slave_d  = slave_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    done_d   = 2'b00;
    sel_d    = sel_q;
    rdn_d    = rdn_q;
    wrn_d    = wrn_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    acc_en   = 1'b0;
    acc_rd   = 1'b0;
    acc_last = 1'b0;
    acc_addr = 3'd0;
    acc_data = 16'h0000;
    pick     = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_d    = '0;
    errp_d   = errp_q;
    err_d    = 1'b0;
`endif

    // Register access selected by the current state
    unique case (state_q)
      S_CLR_STAT: begin acc_en = 1'b1; acc_addr = 3'd2; acc_data = 16'h0000; end
      S_WR_SS:    begin acc_en = 1'b1; acc_addr = 3'd5; acc_data = 16'(slave_q); end
      S_SSO_ON:   begin acc_en = 1'b1; acc_addr = 3'd3; acc_data = 16'h0400; end
      S_WR_TX:    begin acc_en = 1'b1; acc_addr = 3'd1; acc_data = {8'h00, wdata_q[DW-1 -: 8]}; end
      S_RD_RX:    begin acc_en = 1'b1; acc_rd = 1'b1; acc_addr = 3'd0; end
      S_SSO_OFF:  begin acc_en = 1'b1; acc_addr = 3'd3; acc_data = 16'h0000; end
      default:    ;
    endcase

    // Two strobe cycles, then one idle cycle in which the state advances
    if (acc_en) begin
      unique case (ph_q)
        2'd0: begin
          sel_d  = 1'b1;
          rdn_d  = ~acc_rd;
          wrn_d  = acc_rd;
          addr_d = acc_addr;
          dout_d = acc_data;
          ph_d   = 2'd1;
        end
        2'd1: ph_d = 2'd2;
        default: begin
          sel_d    = 1'b0;
          rdn_d    = 1'b1;
          wrn_d    = 1'b1;
          ph_d     = 2'd0;
          acc_last = 1'b1;
        end
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          pick    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          gnt_d   = pick;
          last_d  = pick;
          slave_d = pick ? req1_slave : req0_slave;
          wdata_d = pick ? req1_wdata : req0_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          ph_d    = 2'd0;
          state_d = S_CLR_STAT;
        end
      end
      S_CLR_STAT: if (acc_last) state_d = S_WR_SS;
      S_WR_SS:    if (acc_last) state_d = S_SSO_ON;
      S_SSO_ON:   if (acc_last) state_d = S_WAIT_T;
      S_WAIT_T: begin
        if (readyfordata) state_d = S_WR_TX;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          errp_d  = 1'b1;
          state_d = S_SSO_OFF;
        end else tmo_d = tmo_q + TW'(1);
`endif
      end
      S_WR_TX: begin
        if (acc_last) begin
          wdata_d = wdata_q << 8;
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (dataavailable) state_d = S_RD_RX;
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          errp_d  = 1'b1;
          state_d = S_SSO_OFF;
        end else tmo_d = tmo_q + TW'(1);
`endif
      end
      S_RD_RX: begin
        if (acc_last) begin
          rdata_d = DW'({rdata_q, data_to_cpu[7:0]});
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_d == CW'(NBYTES)) ? S_SSO_OFF : S_WAIT_T;
        end
      end
      S_SSO_OFF: begin
        if (acc_last) begin
          done_d[gnt_q] = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          err_d  = errp_q;
          errp_d = 1'b0;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ph_q    <= 2'd0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      slave_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= 2'b00;
      sel_q   <= 1'b0;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= 3'd0;
      dout_q  <= 16'h0000;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q   <= '0;
      errp_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      slave_q <= slave_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
      errp_q  <= errp_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req0_done     = done_q[0];
  assign req1_done     = done_q[1];
  assign rdata         = rdata_q;
  assign spi_select    = sel_q;
  assign read_n        = rdn_q;
  assign write_n       = wrn_q;
  assign mem_addr      = addr_q;
  assign data_from_cpu = dout_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: SPI core model with MOSI->MISO loopback, access-order and result scoreboards,
// per-access protocol monitor, table-driven arbitration vectors plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_spi_txn_arbiter;
  localparam int unsigned NB  = 4;
  localparam int unsigned NS  = 2;
  localparam int unsigned DW  = 8 * NB;
  localparam int unsigned TMO = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [NS-1:0] req0_slave = '0, req1_slave = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic req0_done, req1_done, err, spi_select, read_n, write_n;
  logic [DW-1:0] rdata;
  logic [2:0] mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu = 16'h0000;
  logic readyfordata = 1'b1;
  logic dataavailable = 1'b0;

  always #5 clk = ~clk;

  spi_txn_arbiter #(.NBYTES(NB), .NSLAVES(NS), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_slave(req0_slave), .req0_wdata(req0_wdata), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_slave(req1_slave), .req1_wdata(req1_wdata), .req1_done(req1_done),
    .rdata(rdata), .err(err), .spi_select(spi_select), .read_n(read_n), .write_n(write_n),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .readyfordata(readyfordata), .dataavailable(dataavailable)
  );

  typedef struct {
    bit v0; bit v1;
    logic [NS-1:0] s0; logic [NS-1:0] s1;
    logic [DW-1:0] w0; logic [DW-1:0] w1;
    logic [7:0] x;
  } vec_t;
  typedef struct packed { logic rd; logic [2:0] addr; logic [15:0] data; } acc_t;
  typedef struct packed { logic id; logic [DW-1:0] rdata; logic err; } res_t;

  acc_t exp_acc[$];
  res_t exp_res[$];
  int n_chk = 0, n_fail = 0;
  bit model_last = 1'b1;
  int acc_count = 0;
  longint cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  int width = 0, idle = 10;
  acc_t cur;
  bit rrdy_stuck = 1'b0;
  logic [7:0] rx_xor = 8'h00, tx_b = 8'h00, rx_b = 8'h00;
  int rr_cnt = 0;
  logic [DW-1:0] last_rdata = '0;

  function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Expected register accesses and result for one full transaction
  function automatic void push_txn(input bit id, input logic [NS-1:0] s, input logic [DW-1:0] w, input logic [7:0] x);
    logic [DW-1:0] r;
    logic [7:0] b;
    r = '0;
    exp_acc.push_back({1'b0, 3'd2, 16'h0000});
    exp_acc.push_back({1'b0, 3'd5, 16'(s)});
    exp_acc.push_back({1'b0, 3'd3, 16'h0400});
    for (int i = 0; i < int'(NB); i++) begin
      b = w[DW-1-8*i -: 8];
      exp_acc.push_back({1'b0, 3'd1, 8'h00, b});
      exp_acc.push_back({1'b1, 3'd0, 16'h0000});
      r = {r[DW-9:0], b ^ x};
    end
    exp_acc.push_back({1'b0, 3'd3, 16'h0000});
    exp_res.push_back({id, r, 1'b0});
  endfunction

  // Protocol monitor, SPI core model and done scoreboard
  always @(negedge clk) begin
    acc_t e;
    res_t r;
    bit act;
    cyc++;
    if (!reset_n) begin
      width = 0; idle = 10; rr_cnt = 0;
      dataavailable = 1'b0; data_to_cpu = 16'h0000;
    end else begin
      chk(!(!read_n && !write_n) && (spi_select || (read_n && write_n)) && !(err && !req0_done && !req1_done),
          "strobe_sanity", {60'h0, spi_select, read_n, write_n, err}, {60'h0, 4'b0110});
      act = spi_select && (!read_n || !write_n);
      if (act) begin
        if (width == 0) begin
          cur = {~read_n, mem_addr, data_from_cpu};
          chk(idle >= 1, "idle_gap", 64'(idle), 64'd1);
          if (!cur.rd && cur.addr == 3'd1) begin tx_b = cur.data[7:0]; rr_cnt = 3; end
          if (cur.rd && cur.addr == 3'd0) begin data_to_cpu = {8'h00, rx_b}; dataavailable = 1'b0; end
        end else begin
          chk({~read_n, mem_addr, data_from_cpu} == cur, "acc_stable",
              64'({~read_n, mem_addr, data_from_cpu}), 64'(cur));
        end
        width++;
      end else if (width != 0) begin
        chk(width == 2, "strobe_width", 64'(width), 64'd2);
        acc_count++;
        if (!cur.rd && cur.addr == 3'd1) last_wr_cyc = cyc;
        if (exp_acc.size() == 0) chk(1'b0, "unexpected_acc", 64'(cur), 64'h0);
        else begin
          e = exp_acc.pop_front();
          chk(cur.rd == e.rd && cur.addr == e.addr && (e.rd || cur.data == e.data), "acc_order", 64'(cur), 64'(e));
        end
        width = 0; idle = 1;
      end else idle++;
      if (rr_cnt > 0) begin
        rr_cnt--;
        if (rr_cnt == 0 && !rrdy_stuck) begin rx_b = tx_b ^ rx_xor; dataavailable = 1'b1; end
      end
      if (req0_done || req1_done) begin
        done_cyc = cyc;
        if (exp_res.size() == 0) chk(1'b0, "unexpected_done", {62'h0, req1_done, req0_done}, 64'h0);
        else begin
          r = exp_res.pop_front();
          chk({req1_done, req0_done} == (r.id ? 2'b10 : 2'b01), "done_id", {62'h0, req1_done, req0_done},
              r.id ? 64'd2 : 64'd1);
          chk(rdata == r.rdata && err == r.err, "result", {31'h0, err, rdata}, {31'h0, r.err, r.rdata});
          last_rdata = r.rdata;
        end
        if (req0_done) req0_valid = 1'b0;
        if (req1_done) req1_valid = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (exp_res.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk(exp_res.size() == 0, "txn_complete", 64'(exp_res.size()), 64'd0);
    chk(exp_acc.size() == 0, "acc_drained", 64'(exp_acc.size()), 64'd0);
    exp_res.delete(); exp_acc.delete();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk(rdata == last_rdata, "rdata_hold", 64'(rdata), 64'(last_rdata));
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_count < target && n < 500) begin @(negedge clk); n++; end
    chk(acc_count >= target, "acc_wait", 64'(acc_count), 64'(target));
  endtask

  task automatic run_vec(input vec_t v);
    bit first;
    @(negedge clk);
    rx_xor = v.x;
    req0_slave = v.s0; req0_wdata = v.w0; req0_valid = v.v0;
    req1_slave = v.s1; req1_wdata = v.w1; req1_valid = v.v1;
    first = (v.v0 && v.v1) ? ~model_last : v.v1;
    push_txn(first, first ? v.s1 : v.s0, first ? v.w1 : v.w0, v.x);
    model_last = first;
    if (v.v0 && v.v1) begin
      push_txn(~first, first ? v.s0 : v.s1, first ? v.w0 : v.w1, v.x);
      model_last = ~first;
    end
    wait_idle();
  endtask

  vec_t vecs[5];
  int base;

  initial begin
    vecs[0] = '{v0:1, v1:1, s0:2'b01, s1:2'b10, w0:32'hA5C30F81, w1:32'hDEADBEEF, x:8'h00};
    vecs[1] = '{v0:1, v1:0, s0:2'b01, s1:2'b00, w0:32'hA5C30F81, w1:32'h0,        x:8'h00};
    vecs[2] = '{v0:1, v1:1, s0:2'b10, s1:2'b01, w0:32'h11223344, w1:32'hCAFEF00D, x:8'hFF};
    vecs[3] = '{v0:0, v1:1, s0:2'b00, s1:2'b01, w0:32'h0,        w1:32'h00FF8001, x:8'h5A};
    vecs[4] = '{v0:1, v1:1, s0:2'b01, s1:2'b10, w0:32'h80000001, w1:32'h7F7F7F7F, x:8'h00};

    repeat (3) @(negedge clk);
    chk(req0_done == 1'b0 && req1_done == 1'b0, "rst_done", {62'h0, req1_done, req0_done}, 64'h0);
    chk(rdata == '0, "rst_rdata", 64'(rdata), 64'h0);
    chk(err == 1'b0, "rst_err", 64'(err), 64'h0);
    chk(spi_select == 1'b0, "rst_select", 64'(spi_select), 64'h0);
    chk(read_n == 1'b1 && write_n == 1'b1, "rst_strobes", {62'h0, read_n, write_n}, 64'h3);
    chk(mem_addr == 3'd0 && data_from_cpu == 16'h0, "rst_bus", {45'h0, mem_addr, data_from_cpu}, 64'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // TRDY held low after SSO_ON: no further access until it rises
    @(negedge clk);
    readyfordata = 1'b0; rx_xor = 8'h00;
    base = acc_count;
    req0_slave = 2'b01; req0_wdata = 32'h13579BDF; req0_valid = 1'b1;
    push_txn(1'b0, 2'b01, 32'h13579BDF, 8'h00); model_last = 1'b0;
    wait_acc(base + 3);
    repeat (50) @(negedge clk);
    chk(acc_count == base + 3, "trdy_hold_no_acc", 64'(acc_count), 64'(base + 3));
    readyfordata = 1'b1;
    wait_idle();

    // Granted requester drops valid and changes inputs: latched copy still completes
    @(negedge clk);
    base = acc_count;
    req1_slave = 2'b10; req1_wdata = 32'h0F1E2D3C; req1_valid = 1'b1;
    push_txn(1'b1, 2'b10, 32'h0F1E2D3C, 8'h00); model_last = 1'b1;
    wait_acc(base + 1);
    req1_valid = 1'b0; req1_wdata = 32'hFFFFFFFF; req1_slave = 2'b01;
    wait_idle();

    // Reset during byte 2, then a fresh transaction
    @(negedge clk);
    base = acc_count;
    req0_slave = 2'b01; req0_wdata = 32'h2468ACE0; req0_valid = 1'b1;
    push_txn(1'b0, 2'b01, 32'h2468ACE0, 8'h00);
    wait_acc(base + 6);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk(read_n == 1'b1 && write_n == 1'b1 && spi_select == 1'b0, "rst_mid_strobes",
        {61'h0, spi_select, read_n, write_n}, 64'h3);
    chk(req0_done == 1'b0 && req1_done == 1'b0, "rst_mid_done", {62'h0, req1_done, req0_done}, 64'h0);
    exp_acc.delete(); exp_res.delete();
    req0_valid = 1'b0; model_last = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_vec('{v0:1, v1:0, s0:2'b10, s1:2'b00, w0:32'h9ABCDEF0, w1:32'h0, x:8'h3C});

`ifdef SPI_ARB_TIMEOUT_EN
    // RRDY never rises: watchdog closes SS and reports err with done
    @(negedge clk);
    rrdy_stuck = 1'b1;
    req0_slave = 2'b01; req0_wdata = 32'h0BADF00D; req0_valid = 1'b1;
    exp_acc.push_back({1'b0, 3'd2, 16'h0000});
    exp_acc.push_back({1'b0, 3'd5, 16'h0001});
    exp_acc.push_back({1'b0, 3'd3, 16'h0400});
    exp_acc.push_back({1'b0, 3'd1, 16'h000B});
    exp_acc.push_back({1'b0, 3'd3, 16'h0000});
    exp_res.push_back({1'b0, 32'h0, 1'b1});
    last_rdata = '0; model_last = 1'b0;
    wait_idle();
    chk(done_cyc - last_wr_cyc == 64'(TMO + 3), "timeout_latency", 64'(done_cyc - last_wr_cyc), 64'(TMO + 3));
    rrdy_stuck = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
